// File: rtl/an_array_decoder_seq.sv
// an_array_decoder_seq: sequential 2-D AN-code array decoder (Barrett reduction,
// row/column error location, one shared single-error AN decoder). Option macro: AN_ARR_SKIP_CLEAN_EN.

module an_decoder_core #(
  parameter int unsigned A  = 37,
  parameter int unsigned CW = 18,
  parameter int unsigned MW = 13,
  parameter int unsigned RW = 6
) (
  input  logic [MW-1:0] quotient,
  input  logic [RW-1:0] residue,
  output logic [MW-1:0] message
);
  // Residue of +2^i or -2^i names the flipped bit; on aliasing the lowest bit (and +) wins.
  always_comb begin
    message = quotient;
    for (int i = int'(CW) - 1; i >= 0; i--) begin
      if (residue == RW'(64'(A) - ((64'd1 << i) % 64'(A))))
        message = quotient + MW'(((64'd1 << i) / 64'(A)) + 64'd1);
      if (residue == RW'((64'd1 << i) % 64'(A)))
        message = quotient - MW'((64'd1 << i) / 64'(A));
    end
  end
endmodule

module an_decoder_n37 #(
  parameter int unsigned CW = 18,
  parameter int unsigned MW = 13,
  parameter int unsigned RW = 6
) (
  input  logic [MW-1:0] quotient,
  input  logic [RW-1:0] residue,
  output logic [MW-1:0] message
);
  an_decoder_core #(.A(37), .CW(CW), .MW(MW), .RW(RW)) u_core (
    .quotient (quotient),
    .residue  (residue),
    .message  (message)
  );
endmodule

module an_decoder_n13 #(
  parameter int unsigned CW = 18,
  parameter int unsigned MW = 13,
  parameter int unsigned RW = 6
) (
  input  logic [MW-1:0] quotient,
  input  logic [RW-1:0] residue,
  output logic [MW-1:0] message
);
  an_decoder_core #(.A(13), .CW(CW), .MW(MW), .RW(RW)) u_core (
    .quotient (quotient),
    .residue  (residue),
    .message  (message)
  );
endmodule

module an_array_decoder_seq #(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5,
  parameter int unsigned A    = 37,
  parameter int unsigned CW   = 18,
  parameter int unsigned MW   = 13,
  parameter int unsigned RW   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*COLS*CW-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS*COLS*MW-1:0]   out_data,
  output logic [7:0]                out_err_cnt,
  output logic                      out_ambig
);
  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned K   = 2 * CW;
  localparam int unsigned PW  = CW + K;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam longint unsigned M = (64'd1 << K) / 64'(A);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [N*CW-1:0] x_q, x_d;
  logic [MW-1:0]   q_q [N];
  logic [MW-1:0]   q_d [N];
  logic [RW-1:0]   r_q [N];
  logic [RW-1:0]   r_d [N];
  logic [ROWS-1:0] er_q, er_d;
  logic [COLS-1:0] ec_q, ec_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RIW-1:0]  row_q, row_d;
  logic [CIW-1:0]  col_q, col_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            ambig_q, ambig_d;

  logic [MW-1:0]   bq_c [N];
  logic [RW-1:0]   br_c [N];
  logic [N-1:0]    berr_c;
  logic [ROWS-1:0] er_c;
  logic [COLS-1:0] ec_c;
  logic [MW-1:0]   dec_q_c, dec_msg_c;
  logic [RW-1:0]   dec_r_c;

  // Barrett reduction of every registered codeword, one conditional fix-up step
  for (genvar k = 0; k < N; k++) begin : g_cell
    logic [CW-1:0] x;
    logic [PW-1:0] prod;
    logic [CW-1:0] qe;
    logic [CW-1:0] re;
    always_comb begin
      x    = x_q[k*CW +: CW];
      prod = PW'(x) * PW'(M);
      qe   = CW'(prod >> K);
      re   = x - CW'(qe * CW'(A));
      if (re >= CW'(A)) begin
        qe = qe + CW'(1);
        re = re - CW'(A);
      end
    end
    assign bq_c[k]   = MW'(qe);
    assign br_c[k]   = RW'(re);
    assign berr_c[k] = (re != '0);
  end

  always_comb begin
    er_c = '0;
    ec_c = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      for (int j = 0; j < int'(COLS); j++) begin
        er_c[i] = er_c[i] | berr_c[i*int'(COLS) + j];
        ec_c[j] = ec_c[j] | berr_c[i*int'(COLS) + j];
      end
    end
  end

  assign dec_q_c = q_q[idx_q];
  assign dec_r_c = r_q[idx_q];

  if (A == 37) begin : g_dec37
    an_decoder_n37 #(.CW(CW), .MW(MW), .RW(RW)) u_dec (
      .quotient (dec_q_c),
      .residue  (dec_r_c),
      .message  (dec_msg_c)
    );
  end else if (A == 13) begin : g_dec13
    an_decoder_n13 #(.CW(CW), .MW(MW), .RW(RW)) u_dec (
      .quotient (dec_q_c),
      .residue  (dec_r_c),
      .message  (dec_msg_c)
    );
  end else begin : g_bad_a
    $error("an_array_decoder_seq: unsupported A=%0d (13 or 37 only)", A);
    assign dec_msg_c = dec_q_c;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    q_d       = q_q;
    r_d       = r_q;
    er_d      = er_q;
    ec_d      = ec_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    err_cnt_d = err_cnt_q;
    ambig_d   = ambig_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = in_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        q_d   = bq_c;
        r_d   = br_c;
        er_d  = er_c;
        ec_d  = ec_c;
        idx_d = '0;
        row_d = '0;
        col_d = '0;
        if (($countones(er_c) > 1) && ($countones(ec_c) > 1)) begin
          ambig_d = 1'b1;
          state_d = ST_DONE;
        end
`ifdef AN_ARR_SKIP_CLEAN_EN
        else if (er_c == '0) begin
          state_d = ST_DONE;
        end
`endif
        else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Cells at a flagged row/column intersection go through the shared decoder
        if (er_q[row_q] && ec_q[col_q]) begin
          q_d[idx_q] = dec_msg_c;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        if (idx_q == IW'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == CIW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RIW'(1);
          end else begin
            col_d = col_q + CIW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          err_cnt_d = '0;
          ambig_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      er_q      <= '0;
      ec_q      <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_cnt_q <= '0;
      ambig_q   <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        q_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      er_q      <= er_d;
      ec_q      <= ec_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_cnt_q <= err_cnt_d;
      ambig_q   <= ambig_d;
      for (int k = 0; k < int'(N); k++) begin
        q_q[k] <= q_d[k];
        r_q[k] <= r_d[k];
      end
    end
  end

  // Ready is withheld for the whole time reset is asserted
  assign in_ready    = (state_q == ST_IDLE) && !rst;
  assign out_valid   = (state_q == ST_DONE);
  assign out_err_cnt = err_cnt_q;
  assign out_ambig   = ambig_q;

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_data[k*MW +: MW] = q_q[k];
  end
endmodule
